// File: rtl/pe_pkg.sv
// Shared PE datapath types and the ReLU/saturation conversion.
// Also used by the PE array output mux, so keep the function interface stable.
package pe_pkg;

    localparam int unsigned PSUM_W = 10;
    localparam int unsigned ACT_W  = 8;

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic signed [ACT_W-1:0]  act_t;

    localparam psum_t ACT_MAX = psum_t'((1 << (ACT_W - 1)) - 1);
    localparam psum_t ACT_MIN = psum_t'(-(1 << (ACT_W - 1)));

    function automatic act_t sat_relu(input psum_t p, input logic relu_en);
        psum_t r;
        r = (relu_en && p[PSUM_W-1]) ? '0 : p;
        if (r > ACT_MAX) begin
            r = ACT_MAX;
        end else if (r < ACT_MIN) begin
            r = ACT_MIN;
        end
        return act_t'(r[ACT_W-1:0]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
// Read data is forced to zero while empty so no stale entry is visible.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty_o masks every unwritten slot.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// PE output drain: selects the capture strobe by dataflow mode, converts psum to an
// activation, and queues results for the next layer's ifmap loader.
module psum_drain
    import pe_pkg::*;
#(
    parameter int unsigned PSUM_W  = pe_pkg::PSUM_W,
    parameter int unsigned ACT_W   = pe_pkg::ACT_W,
    parameter int unsigned DEPTH   = 4,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mode_i,
    input  logic [PSUM_W-1:0]         psum_i,
    input  logic                      psum_valid_i,
    input  logic                      os_capture_i,
    output logic [ACT_W-1:0]          act_o,
    output logic                      act_valid_o,
    input  logic                      act_ready_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      overflow_o,
    input  logic                      clr_ovf_i,
    output logic [15:0]               result_cnt_o
);

    logic             capture;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [ACT_W-1:0] act_conv;
    logic             overflow_q, overflow_d;
    logic [15:0]      result_cnt_q, result_cnt_d;

    always_comb begin
        capture  = mode_i ? psum_valid_i : os_capture_i;
        pop      = !empty && act_ready_i;
        // A pop frees the head slot in the same edge, so a full FIFO still accepts.
        push     = capture && (!full || pop);
        act_conv = sat_relu(psum_t'(psum_i), RELU_EN);

        overflow_d   = (overflow_q && !clr_ovf_i) || (capture && full && !pop);
        result_cnt_d = result_cnt_q + {15'b0, push};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q   <= 1'b0;
            result_cnt_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            result_cnt_q <= result_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (ACT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (act_conv),
        .rdata_o (act_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    assign act_valid_o  = !empty;
    assign overflow_o   = overflow_q;
    assign result_cnt_o = result_cnt_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: one ReLU instance and one bypass instance share stimulus;
// a reference queue per instance tracks expected FIFO contents.
module tb_psum_drain;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, mode, pv, oc, ready, clr;
    logic signed [9:0] psum;

    logic [7:0]  act_r, act_n;
    logic        valid_r, valid_n, ovf_r, ovf_n;
    logic [2:0]  level_r, level_n;
    logic [15:0] cnt_r, cnt_n;

    psum_drain #(.PSUM_W(10), .ACT_W(8), .DEPTH(DEPTH), .RELU_EN(1'b1)) u_relu (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .psum_i(psum), .psum_valid_i(pv),
        .os_capture_i(oc), .act_o(act_r), .act_valid_o(valid_r), .act_ready_i(ready),
        .level_o(level_r), .overflow_o(ovf_r), .clr_ovf_i(clr), .result_cnt_o(cnt_r));

    psum_drain #(.PSUM_W(10), .ACT_W(8), .DEPTH(DEPTH), .RELU_EN(1'b0)) u_norelu (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .psum_i(psum), .psum_valid_i(pv),
        .os_capture_i(oc), .act_o(act_n), .act_valid_o(valid_n), .act_ready_i(ready),
        .level_o(level_n), .overflow_o(ovf_n), .clr_ovf_i(clr), .result_cnt_o(cnt_n));

    int          q_r[$];
    int          q_n[$];
    bit          ovf_m;
    logic [15:0] cnt_m;
    int          passed = 0;
    int          total  = 0;

    function automatic int conv(int p, bit relu);
        int r;
        r = (relu && p < 0) ? 0 : p;
        if (r > 127) return 127;
        if (r < -128) return -128;
        return r;
    endfunction

    // Advance the reference model by the inputs currently driven, then clock once.
    task automatic tick();
        bit cap, full, popm;
        cap  = mode ? pv : oc;
        full = (q_r.size() == DEPTH);
        popm = ready && (q_r.size() != 0);
        if (rst) begin
            q_r.delete();
            q_n.delete();
            ovf_m = 1'b0;
            cnt_m = '0;
        end else begin
            if (popm) begin
                void'(q_r.pop_front());
                void'(q_n.pop_front());
            end
            if (cap && (!full || popm)) begin
                q_r.push_back(conv(int'(psum), 1'b1));
                q_n.push_back(conv(int'(psum), 1'b0));
                cnt_m = cnt_m + 16'd1;
            end
            ovf_m = (ovf_m && !clr) || (cap && full && !popm);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; mode = 1'b1; pv = 1'b0; oc = 1'b0;
        psum = '0; ready = 1'b0; clr = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (valid_r !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_r); else passed++;
        total++; if (act_r !== 8'd0) $display("FAIL reset_act got=%0d exp=0", act_r); else passed++;
        total++; if (level_r !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level_r); else passed++;
        total++; if (ovf_r !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf_r); else passed++;
        total++; if (cnt_r !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt_r); else passed++;
    endtask

    task automatic test_rs_convert();
        int vals[4];
        int expv[4];
        vals = '{45, -20, 300, -300};
        expv = '{45, 0, 127, 0};
        reset_dut();
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            psum = 10'(vals[i]);
            pv = 1'b1;
            tick();
            pv = 1'b0;
            if (i == 0) begin
                total++; if (valid_r !== 1'b1 || act_r !== 8'd45)
                    $display("FAIL rs_latency valid=%b act=%0d exp valid=1 act=45", valid_r, $signed(act_r));
                else passed++;
            end
        end
        total++; if (level_r !== 3'd4) $display("FAIL rs_level got=%0d exp=4", level_r); else passed++;
        total++; if (cnt_r !== 16'd4) $display("FAIL rs_cnt got=%0d exp=4", cnt_r); else passed++;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (valid_r !== 1'b1 || act_r !== 8'(expv[i]) || act_r !== 8'(q_r[0]))
                $display("FAIL rs_pop%0d act=%0d valid=%b exp=%0d", i, $signed(act_r), valid_r, expv[i]);
            else passed++;
            tick();
        end
        ready = 1'b0;
        total++; if (valid_r !== 1'b0 || act_r !== 8'd0)
            $display("FAIL rs_empty valid=%b act=%0d exp valid=0 act=0", valid_r, $signed(act_r));
        else passed++;
    endtask

    task automatic test_relu_bypass();
        int vals[3];
        int expn[3];
        int expr[3];
        vals = '{-300, -128, 511};
        expn = '{-128, -128, 127};
        expr = '{0, 0, 127};
        reset_dut();
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            psum = 10'(vals[i]);
            pv = 1'b1;
            tick();
        end
        pv = 1'b0;
        total++; if (level_n !== 3'd3 || cnt_n !== 16'd3 || ovf_n !== 1'b0)
            $display("FAIL bypass_state level=%0d cnt=%0d ovf=%b exp 3/3/0", level_n, cnt_n, ovf_n);
        else passed++;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (valid_n !== 1'b1 || act_n !== 8'(expn[i]))
                $display("FAIL bypass_pop%0d act=%0d valid=%b exp=%0d", i, $signed(act_n), valid_n, expn[i]);
            else passed++;
            total++; if (act_r !== 8'(expr[i]))
                $display("FAIL relu_pop%0d act=%0d exp=%0d", i, $signed(act_r), expr[i]);
            else passed++;
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic test_os_select();
        reset_dut();
        mode = 1'b0; pv = 1'b1; oc = 1'b0; psum = 10'sd99;
        tick();
        total++; if (valid_r !== 1'b0 || level_r !== 3'd0 || cnt_r !== 16'd0)
            $display("FAIL os_ignore_pv valid=%b level=%0d cnt=%0d exp 0/0/0", valid_r, level_r, cnt_r);
        else passed++;
        pv = 1'b0; oc = 1'b1; psum = 10'sd12;
        tick();
        oc = 1'b0;
        total++; if (valid_r !== 1'b1 || act_r !== 8'd12)
            $display("FAIL os_capture valid=%b act=%0d exp valid=1 act=12", valid_r, $signed(act_r));
        else passed++;
        mode = 1'b1; oc = 1'b1; psum = 10'sd77;
        tick();
        oc = 1'b0;
        total++; if (level_r !== 3'd1 || cnt_r !== 16'd1)
            $display("FAIL rs_ignore_oc level=%0d cnt=%0d exp 1/1", level_r, cnt_r);
        else passed++;
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_full_boundary();
        int expv[4];
        expv = '{20, 30, 40, 60};
        reset_dut();
        mode = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            psum = 10'(v * 10);
            pv = 1'b1;
            tick();
        end
        pv = 1'b0;
        total++; if (level_r !== 3'd4) $display("FAIL full_level got=%0d exp=4", level_r); else passed++;
        total++; if (ovf_r !== 1'b1) $display("FAIL full_ovf got=%b exp=1", ovf_r); else passed++;
        total++; if (cnt_r !== 16'd4) $display("FAIL full_cnt got=%0d exp=4", cnt_r); else passed++;
        total++; if (act_r !== 8'd10) $display("FAIL full_head got=%0d exp=10", $signed(act_r)); else passed++;
        psum = 10'sd60; pv = 1'b1; ready = 1'b1;
        tick();
        pv = 1'b0; ready = 1'b0;
        total++; if (level_r !== 3'd4 || cnt_r !== 16'd5 || act_r !== 8'd20)
            $display("FAIL full_cap_pop level=%0d cnt=%0d head=%0d exp 4/5/20", level_r, cnt_r, $signed(act_r));
        else passed++;
        psum = 10'sd70; pv = 1'b1; clr = 1'b1;
        tick();
        pv = 1'b0; clr = 1'b0;
        total++; if (ovf_r !== 1'b1 || cnt_r !== 16'd5 || level_r !== 3'd4)
            $display("FAIL ovf_set_wins ovf=%b cnt=%0d level=%0d exp 1/5/4", ovf_r, cnt_r, level_r);
        else passed++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (ovf_r !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf_r); else passed++;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (valid_r !== 1'b1 || act_r !== 8'(expv[i]))
                $display("FAIL full_drain%0d act=%0d valid=%b exp=%0d", i, $signed(act_r), valid_r, expv[i]);
            else passed++;
            tick();
        end
        tick();
        total++; if (valid_r !== 1'b0 || level_r !== 3'd0 || act_r !== 8'd0)
            $display("FAIL ready_empty valid=%b level=%0d act=%0d exp 0/0/0", valid_r, level_r, $signed(act_r));
        else passed++;
        psum = 10'sd33; pv = 1'b1;
        tick();
        pv = 1'b0; ready = 1'b0;
        total++; if (valid_r !== 1'b1 || act_r !== 8'd33 || level_r !== 3'd1)
            $display("FAIL no_bypass valid=%b act=%0d level=%0d exp 1/33/1", valid_r, $signed(act_r), level_r);
        else passed++;
    endtask

    task automatic test_random_backpressure();
        int exp_act;
        reset_dut();
        for (int i = 0; i < 1000; i++) begin
            mode  = 1'($urandom_range(0, 1));
            pv    = ($urandom_range(0, 9) < 6);
            oc    = ($urandom_range(0, 9) < 6);
            psum  = 10'($urandom_range(0, 1023));
            ready = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 7) == 0);
            rst   = (i == 500);
            exp_act = (q_r.size() != 0) ? q_r[0] : 0;
            total++; if (valid_r !== (q_r.size() != 0))
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, valid_r, q_r.size() != 0);
            else passed++;
            total++; if (act_r !== 8'(exp_act))
                $display("FAIL rnd_act cyc=%0d got=%0d exp=%0d", i, $signed(act_r), exp_act);
            else passed++;
            total++; if (level_r !== 3'(q_r.size()))
                $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level_r, q_r.size());
            else passed++;
            total++; if (ovf_r !== ovf_m)
                $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, ovf_r, ovf_m);
            else passed++;
            total++; if (cnt_r !== cnt_m)
                $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, cnt_r, cnt_m);
            else passed++;
            total++; if (valid_n !== valid_r || (q_n.size() != 0 && act_n !== 8'(q_n[0])))
                $display("FAIL rnd_bypass_act cyc=%0d got=%0d exp=%0d", i, $signed(act_n),
                         (q_n.size() != 0) ? q_n[0] : 0);
            else passed++;
            tick();
            if (i == 500) begin
                total++; if (valid_r !== 1'b0 || level_r !== 3'd0 || cnt_r !== 16'd0)
                    $display("FAIL mid_reset valid=%b level=%0d cnt=%0d exp 0/0/0", valid_r, level_r, cnt_r);
                else passed++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        ovf_m = 1'b0;
        cnt_m = '0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_rs_convert();
        test_relu_bypass();
        test_os_select();
        test_full_boundary();
        test_random_backpressure();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
